bitty_sequencer: RTL and testbench

Program sequencer for the bitty core. Holds a program counter, reads 16-bit instructions from a synchronous-read instruction memory, and presents each one to the core. For each instruction it pulses the core's `run` input, waits for `done`, then advances. It supports a programmable address window, an external halt request, and a watchdog that aborts when the core hangs.

---
 rtl/bitty_sequencer.sv | 156 +++++++++++++++
 tb/tb_bitty_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_sequencer.sv
// Program sequencer for the bitty core: fetches 16-bit instructions over a window,
// hands each to the core with a run pulse and waits for done under a watchdog.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs quiet
// S_FETCH | mem_rd asserted with mem_addr = pc
// S_WAIT  | memory data returns; captured into instruction
// S_ISSUE | run pulse to the core; watchdog loaded
// S_EXEC  | waiting for core_done; watchdog counts down to terminal zero
module bitty_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              halt_req,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              core_done,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
  localparam logic [15:0]     CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;
  logic              halt_q, halt_d;
  logic              fin_q, fin_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      end_q   <= '0;
      instr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
      fin_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      end_q   <= end_d;
      instr_q <= instr_d;
      count_q <= count_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      fin_q   <= fin_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    end_d   = end_q;
    instr_d = instr_q;
    count_d = count_q;
    err_d   = err_q;
    halt_d  = halt_q;
    fin_d   = 1'b0;
    wdog_d  = wdog_q;

    // A halt is only remembered here; it takes effect at the next completion.
    if (state_q != S_IDLE && halt_req) begin
      halt_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          end_d   = end_addr;
          count_d = '0;
          err_d   = 1'b0;
          halt_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        instr_d = mem_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wdog_d  = WD_LOAD;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (core_done) begin
          if (count_q != CNT_MAX) begin
            count_d = count_q + 16'd1;
          end
          if (pc_q == end_q || halt_q || halt_req) begin
            fin_d   = 1'b1;
            halt_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (wdog_q == '0) begin
          // Terminal count reached on the TIMEOUT-th EXEC cycle without done.
          err_d   = 1'b1;
          halt_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_rd      = (state_q == S_FETCH);
  assign mem_addr    = pc_q;
  assign run         = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign finished    = fin_q;
  assign error       = err_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_bitty_sequencer.sv
// Self-checking bench for bitty_sequencer: directed table, corner sequences and
// randomized programs compared against a window/halt reference model.
module tb_bitty_sequencer;
  localparam int AW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic          halt_req;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic [15:0]   instruction;
  logic          run;
  logic          core_done;
  logic          busy;
  logic          finished;
  logic          error;
  logic [AW-1:0] pc;
  logic [15:0]   instr_count;

  bitty_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .halt_req(halt_req), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .instruction(instruction),
    .run(run), .core_done(core_done), .busy(busy), .finished(finished),
    .error(error), .pc(pc), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // synchronous-read instruction memory
  logic [15:0] mem [256];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  // core model: done in the L-th cycle after run (L=0 never, L<0 random 1..5)
  int   core_lat;
  int   lat_now;
  int   cd;
  logic done_m;
  logic inj;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cd     <= 0;
      done_m <= 1'b0;
    end else if (run) begin
      lat_now = (core_lat < 0) ? int'($urandom_range(5, 1)) : core_lat;
      done_m <= (lat_now == 1);
      cd     <= (lat_now > 1) ? lat_now - 1 : 0;
    end else if (cd > 0) begin
      cd     <= cd - 1;
      done_m <= (cd == 1);
    end else begin
      done_m <= 1'b0;
    end
  end
  assign core_done = done_m | inj;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // observations of one program run
  logic [7:0]  o_addr[$];
  logic [15:0] o_instr[$];
  int o_fin, o_idle_at, o_run_first, o_first_rd;

  task automatic run_prog(input logic [7:0] s, input logic [7:0] e,
                          input int halt_k, input int poke_k, input int budget);
    int nf;
    nf = 0;
    o_addr.delete();
    o_instr.delete();
    o_fin = 0; o_idle_at = -1; o_run_first = -1; o_first_rd = -1;
    @(negedge clk);
    start = 1'b1; start_addr = s; end_addr = e;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (mem_rd) begin
        o_addr.push_back(mem_addr);
        nf++;
        if (o_first_rd < 0) o_first_rd = n;
      end
      halt_req   = mem_rd && (nf == halt_k);
      start      = mem_rd && (nf == poke_k);
      inj        = mem_rd && (nf == poke_k);
      start_addr = s + 8'h40;
      if (run) begin
        o_instr.push_back(instruction);
        if (o_run_first < 0) o_run_first = n;
      end
      if (finished) o_fin++;
      if (!busy) begin
        o_idle_at = n;
        break;
      end
      @(negedge clk);
    end
    halt_req = 1'b0; start = 1'b0; inj = 1'b0;
  endtask

  // reference: addresses walk the window modulo 256, stopping at end or at the halted fetch
  logic [7:0] x_addr[$];
  task automatic build_exp(input logic [7:0] s, input logic [7:0] e, input int halt_k);
    logic [7:0] a;
    x_addr.delete();
    a = s;
    for (int i = 1; i <= 256; i++) begin
      x_addr.push_back(a);
      if (a == e || i == halt_k) break;
      a = a + 8'd1;
    end
  endtask

  task automatic check_run(input string tag, input int exp_cnt,
                           input logic [7:0] exp_pc, input int lat);
    int m;
    chk({tag, " n_fetch"}, o_addr.size(), x_addr.size());
    chk({tag, " n_run"}, o_instr.size(), x_addr.size());
    m = (o_addr.size() < x_addr.size()) ? o_addr.size() : x_addr.size();
    for (int i = 0; i < m; i++) chk({tag, " addr"}, o_addr[i], x_addr[i]);
    m = (o_instr.size() < x_addr.size()) ? o_instr.size() : x_addr.size();
    for (int i = 0; i < m; i++) chk({tag, " instr"}, o_instr[i], mem[x_addr[i]]);
    chk({tag, " finished"}, o_fin, 1);
    chk({tag, " count"}, instr_count, exp_cnt);
    chk({tag, " pc"}, pc, exp_pc);
    chk({tag, " error"}, error, 0);
    chk({tag, " first_rd"}, o_first_rd, 0);
    chk({tag, " first_run"}, o_run_first, 2);
    if (lat > 0) chk({tag, " idle_at"}, o_idle_at, x_addr.size() * (3 + lat));
  endtask

  typedef struct {
    logic [7:0] s;
    logic [7:0] e;
    int         halt_k;
    int         lat;
    int         cnt;
    logic [7:0] pc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'h10, 8'h12, 0, 2, 3, 8'h12};
    tbl[1] = '{8'hFE, 8'h01, 0, 1, 4, 8'h01};
    tbl[2] = '{8'h00, 8'h0F, 3, 2, 3, 8'h02};
    tbl[3] = '{8'h33, 8'h33, 0, 3, 1, 8'h33};
    tbl[4] = '{8'h20, 8'h27, 0, 4, 8, 8'h27};

    for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
    mem[8'h10] = 16'hA001;
    mem[8'h11] = 16'hA002;
    mem[8'h12] = 16'hA003;

    reset = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0;
    halt_req = 1'b0; inj = 1'b0; core_lat = 2;
    repeat (3) @(negedge clk);
    chk("rst pc", pc, 0);
    chk("rst instruction", instruction, 0);
    chk("rst count", instr_count, 0);
    chk("rst run", run, 0);
    chk("rst mem_rd", mem_rd, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst busy", busy, 0);
    chk("rst finished", finished, 0);
    chk("rst error", error, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle busy", busy, 0);

    for (int t = 0; t < 5; t++) begin
      core_lat = tbl[t].lat;
      build_exp(tbl[t].s, tbl[t].e, tbl[t].halt_k);
      run_prog(tbl[t].s, tbl[t].e, tbl[t].halt_k, 0, 400);
      check_run($sformatf("vec%0d", t), tbl[t].cnt, tbl[t].pc, tbl[t].lat);
    end

    // watchdog: core never completes
    core_lat = 0;
    run_prog(8'h50, 8'h58, 0, 0, 200);
    chk("wdog n_run", o_instr.size(), 1);
    chk("wdog finished", o_fin, 0);
    chk("wdog error", error, 1);
    chk("wdog count", instr_count, 0);
    chk("wdog busy_drop", o_idle_at - o_run_first, TO + 1);

    core_lat = 2;
    build_exp(8'h10, 8'h12, 0);
    run_prog(8'h10, 8'h12, 0, 0, 400);
    check_run("after_wdog", 3, 8'h12, 2);

    // start re-pulsed and core_done injected during the second fetch
    build_exp(8'h60, 8'h63, 0);
    run_prog(8'h60, 8'h63, 0, 2, 400);
    check_run("poke", 4, 8'h63, 2);

    // reset while executing the second instruction
    core_lat = 3;
    begin
      int nrun;
      bit seen;
      nrun = 0; seen = 1'b0;
      @(negedge clk);
      start = 1'b1; start_addr = 8'h10; end_addr = 8'h12;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 100; n++) begin
        if (run) nrun++;
        if (nrun == 2) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("rexec reached", seen, 1);
      @(negedge clk);
      chk("rexec pre count", instr_count, 1);
      reset = 1'b0;
      #1;
      chk("rexec run", run, 0);
      chk("rexec mem_rd", mem_rd, 0);
      chk("rexec busy", busy, 0);
      chk("rexec pc", pc, 0);
      chk("rexec count", instr_count, 0);
      chk("rexec finished", finished, 0);
      @(negedge clk);
      chk("rexec hold mem_rd", mem_rd, 0);
      chk("rexec hold finished", finished, 0);
      reset = 1'b1;
      @(negedge clk);
    end
    core_lat = 2;
    build_exp(8'h10, 8'h12, 0);
    run_prog(8'h10, 8'h12, 0, 0, 400);
    check_run("after_rst", 3, 8'h12, 2);

    // randomized programs with random latency and occasional halts
    core_lat = -1;
    for (int r = 0; r < 20; r++) begin
      logic [7:0] s, e;
      int len, hk;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      s   = 8'($urandom);
      len = $urandom_range(6, 1);
      e   = s + 8'(len - 1);
      hk  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len, 1)) : 0;
      build_exp(s, e, hk);
      run_prog(s, e, hk, 0, 600);
      check_run($sformatf("rnd%0d", r), x_addr.size(), x_addr[x_addr.size() - 1], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
